// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO.
// Bus-visible TXDATA/STATUS/DIVISOR/CTRL registers and a drain interrupt.
module uart_tx_mmio #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd,
    output logic        tx_int_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    // Bus decode
    logic       wr_en;
    logic [1:0] reg_a;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       ovf_set;
    logic       ovf_clr;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          empty;
    logic [7:0]    head;

    // Registers
    logic [15:0] div_q, div_d;
    logic [15:0] div_eff;
    logic        tx_en_q, tx_en_d;
    logic        int_en_q, int_en_d;
    logic        ovf_q, ovf_d;

    // Serial engine
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        last;
    logic        busy;

    logic [31:0] rdata;
    logic        unused_ok;

    assign wr_en    = ce & we;
    assign reg_a    = addr[3:2];
    assign push_req = wr_en & (reg_a == A_TXDATA) & sel[0];
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    // Full is judged on pre-edge occupancy, even if a pop lands on this edge
    assign push     = push_req & ~full;
    assign ovf_set  = push_req & full;
    assign ovf_clr  = wr_en & (reg_a == A_STATUS) & sel[0] & data_i[3];
    assign head     = mem_q[rptr_q];
    assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
    assign last     = (cnt_q == 16'd1);
    assign busy     = (state_q != S_IDLE);

    assign unused_ok = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16]};

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= data_i[7:0];
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Software-visible control registers and sticky overflow
    always_comb begin
        div_d    = div_q;
        tx_en_d  = tx_en_q;
        int_en_d = int_en_q;
        ovf_d    = ovf_q;
        if (wr_en && reg_a == A_DIV) begin
            if (sel[0]) div_d[7:0]  = data_i[7:0];
            if (sel[1]) div_d[15:8] = data_i[15:8];
        end
        if (wr_en && reg_a == A_CTRL && sel[0]) begin
            tx_en_d  = data_i[0];
            int_en_d = data_i[1];
        end
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // Frame sequencer: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tx_en_q && !empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = div_eff;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last) begin
                    cnt_d   = div_eff;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (last) begin
                    cnt_d = div_eff;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (last) begin
                    // Chain straight into the next frame with no idle gap
                    if (tx_en_q && !empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        cnt_d   = div_eff;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the next state so txd is a clean flop output
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            div_q    <= DIV_RESET;
            tx_en_q  <= 1'b0;
            int_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            txd_q    <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            div_q    <= div_d;
            tx_en_q  <= tx_en_d;
            int_en_q <= int_en_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end

    // Register read mux; side-effect free
    always_comb begin
        rdata = 32'h0;
        unique case (reg_a)
            A_TXDATA: rdata = 32'h0;
            A_STATUS: begin
                rdata[0]      = busy;
                rdata[1]      = full;
                rdata[2]      = empty;
                rdata[3]      = ovf_q;
                rdata[8 +: CW] = count_q;
            end
            A_DIV:    rdata[15:0] = div_q;
            A_CTRL:   rdata[1:0]  = {int_en_q, tx_en_q};
            default:  rdata = 32'h0;
        endcase
    end

    assign data_o   = (ce && !we) ? rdata : 32'h0;
    assign txd      = txd_q;
    assign tx_int_o = int_en_q & empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench for uart_tx_mmio.
// Driver queues expected bytes; a line monitor decodes and checks frames.
module tb_uart_tx_mmio;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        txd;
    logic        tx_int_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int frames = 0;
    int exp_div = 434;
    bit mon_en = 1'b0;
    logic [7:0] sb[$];
    int starts[$];

    uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o), .txd(txd), .tx_int_o(tx_int_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = {28'h0, a, 2'b00}; sel = s; data_i = d;
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = 32'h0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b0; addr = {28'h0, a, 2'b00}; sel = 4'hf;
        #1;
        d = data_o;
        ce = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus_wr(2'd0, {24'h0, b}, 4'h1);
        sb.push_back(b);
    endtask

    task automatic set_div(input int d);
        bus_wr(2'd2, 32'(d), 4'h3);
        exp_div = (d == 0) ? 1 : d;
    endtask

    // Wait until FIFO empty and engine idle, bounded by a read budget
    task automatic wait_drain(input string name, input int budget);
        logic [31:0] v;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            bus_rd(2'd1, v);
            if ((v & 32'h7) == 32'h4) ok = 1'b1;
        end
        if (!ok) check({name, "_drain_timeout"}, v & 32'h7, 32'h4);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    // Line monitor: samples every cycle of a frame against the ideal 8N1 waveform
    initial begin : monitor
        logic prev;
        int d, s, errs, idx;
        logic [7:0] e, g;
        logic eb;
        bit have;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev === 1'b1 && txd === 1'b0) begin
                s = cyc; d = exp_div; errs = 0; g = 8'h0; e = 8'h0;
                have = (sb.size() != 0);
                if (have) e = sb.pop_front();
                for (int j = 0; j < 10 * d; j++) begin
                    if (j > 0) @(negedge clk);
                    idx = j / d - 1;
                    if (j < d) eb = 1'b0;
                    else if (j < 9 * d) eb = e[idx];
                    else eb = 1'b1;
                    if (txd !== eb) errs++;
                    if (j >= d && j < 9 * d && (j % d) == d / 2) g[idx] = txd;
                end
                starts.push_back(s);
                frames++;
                total++;
                if (!have || errs != 0) begin
                    bad++;
                    $display("FAIL frame@%0d: got %02h (%0d bad samples) expected %02h queued=%0d",
                             s, g, errs, e, have);
                end
                prev = 1'b1;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin : stim
        logic [31:0] v;
        int n, f0, nb, d;
        logic [7:0] b;
        ce = 0; we = 0; addr = 0; sel = 0; data_i = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Reset mid-frame
        set_div(4);
        bus_wr(2'd3, 32'h1, 4'h1);
        bus_wr(2'd0, 32'h3c, 4'h1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("txd_low_midframe", {31'h0, txd}, 32'h0);
        rst = 1'b0;
        #1;
        check("txd_reset", {31'h0, txd}, 32'h1);
        check("int_reset", {31'h0, tx_int_o}, 32'h0);
        @(negedge clk) rst = 1'b1;
        exp_div = 434;
        bus_rd(2'd1, v); check("status_reset", v, 32'h4);
        bus_rd(2'd2, v); check("div_reset", v, 32'd434);
        bus_rd(2'd3, v); check("ctrl_reset", v, 32'h0);
        bus_rd(2'd0, v); check("txdata_read", v, 32'h0);
        mon_en = 1'b1;

        // Single frame, D=4
        set_div(4);
        bus_wr(2'd3, 32'h1, 4'h1);
        bus_rd(2'd2, v); check("div_rb", v, 32'd4);
        bus_rd(2'd3, v); check("ctrl_rb", v, 32'h1);
        starts.delete();
        push(8'ha5);
        n = wr_cyc;
        repeat (40) @(posedge clk);
        bus_rd(2'd1, v); check("busy_at_N40", v & 32'h1, 32'h1);
        bus_rd(2'd1, v); check("busy_at_N41", v & 32'h1, 32'h0);
        check("single_starts", starts.size(), 1);
        if (starts.size() == 1) check("single_start_cyc", starts[0], n + 1);

        // Back-to-back, D=2
        set_div(2);
        starts.delete();
        push(8'h11);
        n = wr_cyc;
        push(8'he7);
        push(8'h5a);
        wait_drain("b2b", 200);
        check("b2b_starts", starts.size(), 3);
        if (starts.size() == 3) begin
            check("b2b_first", starts[0], n + 1);
            check("b2b_gap1", starts[1] - starts[0], 20);
            check("b2b_gap2", starts[2] - starts[1], 20);
        end

        // Overflow with tx disabled
        bus_wr(2'd3, 32'h0, 4'h1);
        f0 = frames;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) push(b);
            else bus_wr(2'd0, {24'h0, b}, 4'h1);
        end
        bus_rd(2'd1, v); check("ovf_status", v, 32'h0000_080a);
        bus_wr(2'd1, 32'h8, 4'h1);
        bus_rd(2'd1, v); check("ovf_cleared", v, 32'h0000_0802);
        bus_wr(2'd3, 32'h1, 4'h1);
        wait_drain("ovf", 400);
        check("ovf_frames", frames - f0, DEPTH);

        // Interrupt, D=2
        bus_wr(2'd3, 32'h3, 4'h1);
        check("int_idle", {31'h0, tx_int_o}, 32'h1);
        push(8'hc3);
        check("int_push", {31'h0, tx_int_o}, 32'h0);
        repeat (20) @(posedge clk);
        #1 check("int_N20", {31'h0, tx_int_o}, 32'h0);
        @(posedge clk);
        #1 check("int_N21", {31'h0, tx_int_o}, 32'h1);
        bus_wr(2'd3, 32'h1, 4'h1);
        check("int_disabled", {31'h0, tx_int_o}, 32'h0);
        push(8'h3e);
        wait_drain("intoff", 200);
        check("int_stays_low", {31'h0, tx_int_o}, 32'h0);

        // Clearing tx_en finishes the current frame only
        f0 = frames;
        push(8'h81);
        push(8'h42);
        repeat (5) @(posedge clk);
        bus_wr(2'd3, 32'h0, 4'h1);
        repeat (30) @(posedge clk);
        bus_rd(2'd1, v); check("txen_off_status", v, 32'h0000_0100);
        check("txen_off_frames", frames - f0, 1);
        bus_wr(2'd3, 32'h1, 4'h1);
        wait_drain("txen_on", 200);

        // Bus decode
        @(negedge clk);
        ce = 1'b0; we = 1'b0; addr = 32'h4;
        #1 check("ce0_read", data_o, 32'h0);
        bus_wr(2'd2, 32'h0000_ab77, 4'b0010);
        bus_rd(2'd2, v); check("div_hi_only", v, 32'h0000_ab02);
        bus_wr(2'd0, 32'h0000_00ff, 4'b1110);
        bus_rd(2'd1, v); check("txdata_nosel", v, 32'h4);

        // Divisor 0 behaves as 1
        set_div(0);
        bus_rd(2'd2, v); check("div_zero_rb", v, 32'h0);
        push(8'h96);
        wait_drain("div0", 100);

        // Random rounds
        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(1, 5);
            set_div(d);
            nb = $urandom_range(1, DEPTH);
            f0 = frames;
            for (int i = 0; i < nb; i++) begin
                push(8'($urandom));
                repeat ($urandom_range(0, 12)) @(posedge clk);
            end
            wait_drain("rand", 1000);
            check("rand_frames", frames - f0, nb);
            bus_rd(2'd1, v); check("rand_no_ovf", v & 32'h8, 32'h0);
        end

        check("sb_final", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, alongside the data RAM: it consumes the same ce/we/addr/sel/data bus the core drives toward memory, once the external address decoder has selected it. Software writes bytes into an internal FIFO, and a serial engine shifts them out as 8N1 frames on `txd`. A level interrupt to the core's `int` vector reports when the transmitter has drained.

## Interface
Parameters:
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..16.
- DIV_RESET, 16'd434: reset value of DIVISOR, in clk cycles per bit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ce  in  1  block select from the address decoder.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address; only addr[3:2] is decoded.
- sel  in  4  byte lanes; sel[0] covers data[7:0].
- data_i  in  32  write data.
- data_o  out  32  read data, combinational.
- txd  out  1  serial output, idle high.
- tx_int_o  out  1  level interrupt.

## Operation
Register map (addr[3:2]):
- 0 TXDATA
  - Write with sel[0]=1 pushes data_i[7:0].
  - Reads return 0.
- 1 STATUS, read-only except bit3:
  - bit0: busy (FSM not IDLE).
  - bit1: full.
  - bit2: empty.
  - bit3: overflow (sticky). A write with sel[0]=1 and data_i[3]=1 clears it.
  - bits[8+:CW]: FIFO count, where CW = log2(FIFO_DEPTH)+1.
  - All other bits read 0.
- 2 DIVISOR, 16 bits:
  - sel[0] writes [7:0]; sel[1] writes [15:8].
  - An effective value of 0 is treated as 1.
- 3 CTRL:
  - bit0: tx_en.
  - bit1: int_en.
  - sel[0] required to write.

Bus access:
- A write is an access with ce=1, we=1, taking effect on the clock edge.
- data_o = register value when ce=1 and we=0; otherwise 32'h0.
- Reads have no side effects.

FIFO:
- A push while full is dropped and sets overflow. The full check uses pre-edge state, even if a pop occurs on the same edge.
- A simultaneous push and pop leaves the count unchanged.

FSM states: IDLE, START, DATA, STOP.
- IDLE: txd=1. If tx_en=1 and the FIFO is non-empty, pop the head into an 8-bit shift register, load the bit counter with DIVISOR, and go to START.
- START: txd=0 for DIVISOR cycles, then go to DATA.
- DATA: transmit 8 bits LSB first, each held for DIVISOR cycles, then go to STOP.
- STOP: txd=1 for DIVISOR cycles. On the last cycle, if tx_en=1 and the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Clearing tx_en never aborts a frame in progress; it only prevents the next pop.
- DIVISOR changes take effect at the next bit-counter reload.

Interrupt:
- tx_int_o = int_en & empty & (state==IDLE).
- It is derived only from registered state and has no combinational path from bus inputs.

Reset (rst=0, asynchronous):
- txd=1, tx_int_o=0.
- FIFO emptied; overflow=0.
- DIVISOR=DIV_RESET, CTRL=0, FSM=IDLE.
- A frame in progress is abandoned immediately.

## Timing
- Push at edge N: count and empty update at edge N.
- With the FSM in IDLE and tx_en=1, the pop occurs at edge N+1, and txd=0 from N+1.
- With DIVISOR=D:
  - txd carries bit k from edge N+1+(k+1)·D.
  - The stop bit starts at N+1+9·D.
  - The frame ends at N+1+10·D.
- Back-to-back frames: each frame is exactly 10·D cycles, with no extra cycle between them.
- STATUS.busy goes high at the pop edge and low at the edge entering IDLE.
- CTRL and DIVISOR writes are visible on read from the following cycle.

## Test plan
- Reset values: assert rst=0 mid-frame → txd=1 immediately; after release, STATUS reads 32'h0000_0004, DIVISOR reads 434, CTRL reads 0, tx_int_o=0.
- Single frame: DIVISOR=4, CTRL=1, write 8'hA5 at edge N → txd=0 over N+1..N+5, then bits 1,0,1,0,0,1,0,1 each for 4 cycles, then stop=1; busy falls at N+41.
- Back-to-back: DIVISOR=2, CTRL=1, push 3 bytes in consecutive cycles → 60 contiguous cycles of framing with no idle gap; count goes 1→2→(pops)…→0.
- Overflow: CTRL=0, push 9 bytes with FIFO_DEPTH=8 → full=1, count=8, overflow=1, 9th byte absent from output. Write 8 to STATUS → overflow=0. Set tx_en=1 → exactly 8 frames.
- Interrupt: CTRL=3, push 1 byte → tx_int_o drops at the push edge and returns high when the FSM re-enters IDLE after stop. With int_en=0 it stays 0.
- Bus decode: read with ce=0 → data_o=0. DIVISOR write with sel=4'b0010 → only [15:8] changes. TXDATA write with sel[0]=0 → no push.
